// File: rtl/mux2_burst_arbiter.sv
`timescale 1ns/1ps
// mux2_burst_arbiter
// Round-robin burst arbiter in front of a shared 2:1 data mux. It grants one of
// two requesters for a burst, drives the registered mux select, and feeds the
// selected beats into a one-entry registered output stage.
//
// Ports
//   clk, reset               : single clock, synchronous active-high reset
//   req_valid_n/data_n/last_n: requester n beat (n = 0, 1)
//   req_ready_n              : requester n beat accepted this cycle
//   out_valid/data/last/src  : registered output beat and the port it came from
//   out_ready                : consumer accepts the registered beat
//   sel                      : registered mux select (0 = port 0, 1 = port 1)
//   busy                     : high while a grant is active
//   state_dbg                : current FSM state, for checkers
//
// Handshake: every valid/ready pair transfers exactly one beat on a rising
// clock edge where both are high. A source never withdraws data because ready
// is low, and ready never depends combinationally on the matching valid.
module mux2_burst_arbiter #(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid_0,
   input  logic [DATA_W-1:0] req_data_0,
   input  logic              req_last_0,
   output logic              req_ready_0,
   input  logic              req_valid_1,
   input  logic [DATA_W-1:0] req_data_1,
   input  logic              req_last_1,
   output logic              req_ready_1,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              out_src,
   input  logic              out_ready,
   output logic              sel,
   output logic              busy,
   output logic [1:0]        state_dbg
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] GRANT0 = 2'd1;
   localparam logic [1:0] GRANT1 = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             prio;
   logic [CNT_W-1:0] cnt;

   logic              out_free;
   logic              accept_0;
   logic              accept_1;
   logic              accept;
   logic              acc_src;
   logic              acc_last;
   logic [DATA_W-1:0] acc_data;
   logic              burst_full;
   logic              grant_end;

   // The output register can take a beat if it is empty or draining this cycle.
   assign out_free    = !out_valid || out_ready;
   assign req_ready_0 = (state == GRANT0) && out_free;
   assign req_ready_1 = (state == GRANT1) && out_free;

   assign accept_0 = req_valid_0 && req_ready_0;
   assign accept_1 = req_valid_1 && req_ready_1;
   assign accept   = accept_0 || accept_1;

   // Only the granted port can be accepted, so the state picks the source.
   assign acc_src  = (state == GRANT1);
   assign acc_last = acc_src ? req_last_1 : req_last_0;
   assign acc_data = acc_src ? req_data_1 : req_data_0;

   // cnt counts beats already taken in this grant; the beat being accepted now
   // is the last allowed one when cnt has reached MAX_BURST-1.
   assign burst_full = (cnt == CNT_W'(MAX_BURST - 1));
   assign grant_end  = accept && (acc_last || burst_full);

   assign busy      = (state != IDLE);
   assign state_dbg = state;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_valid_0 && (!req_valid_1 || !prio))
               state_nxt = GRANT0;
            else if (req_valid_1)
               state_nxt = GRANT1;
         end
         GRANT0, GRANT1: begin
            if (grant_end)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         sel       <= 1'b0;
         prio      <= 1'b0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_src   <= 1'b0;
      end else begin
         state <= state_nxt;

         // sel follows the new grant on the same edge; it holds through IDLE.
         if (state == IDLE && state_nxt != IDLE)
            sel <= (state_nxt == GRANT1);

         if (grant_end) begin
            cnt  <= '0;
            prio <= !acc_src;
         end else if (accept) begin
            cnt <= cnt + 1'b1;
         end

         // A beat accepted in the same cycle as a drain reloads the register,
         // so out_valid stays high.
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= acc_data;
            out_last  <= acc_last;
            out_src   <= acc_src;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux2_burst_arbiter.sv
`timescale 1ns/1ps
module tb_mux2_burst_arbiter;

   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              req_valid_0 = 1'b0;
   logic [DATA_W-1:0] req_data_0 = '0;
   logic              req_last_0 = 1'b0;
   logic              req_ready_0;
   logic              req_valid_1 = 1'b0;
   logic [DATA_W-1:0] req_data_1 = '0;
   logic              req_last_1 = 1'b0;
   logic              req_ready_1;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_src;
   logic              out_ready = 1'b1;
   logic              sel;
   logic              busy;
   logic [1:0]        state_dbg;

   // Requester beat queues ({last, data}), consumer log ({src, last, data}).
   logic [DATA_W:0]   q0[$];
   logic [DATA_W:0]   q1[$];
   logic [DATA_W+1:0] got_q[$];
   logic [DATA_W+1:0] exp_q[$];
   logic              gap_0 = 1'b0;

   int tests_run    = 0;
   int tests_failed = 0;

   mux2_burst_arbiter #(.DATA_W(DATA_W), .MAX_BURST(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid_0(req_valid_0), .req_data_0(req_data_0), .req_last_0(req_last_0),
      .req_ready_0(req_ready_0),
      .req_valid_1(req_valid_1), .req_data_1(req_data_1), .req_last_1(req_last_1),
      .req_ready_1(req_ready_1),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
      .out_ready(out_ready), .sel(sel), .busy(busy), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   // ---------------- drivers and monitor ----------------
   // Acceptance and consumption are recorded at the active edge.
   always @(posedge clk) begin
      if (!reset) begin
         if (req_valid_0 && req_ready_0) void'(q0.pop_front());
         if (req_valid_1 && req_ready_1) void'(q1.pop_front());
         if (out_valid && out_ready) got_q.push_back({out_src, out_last, out_data});
      end
   end

   // Requesters present their head beat from the falling edge.
   always @(negedge clk) begin
      req_valid_0 = (q0.size() != 0) && !gap_0;
      {req_last_0, req_data_0} = (q0.size() != 0) ? q0[0] : '0;
      req_valid_1 = (q1.size() != 0);
      {req_last_1, req_data_1} = (q1.size() != 0) ? q1[0] : '0;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic restart;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      got_q.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset = 1'b1;
      tick(2);
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      tests_run++; if (out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_out_data got=%0h exp=00", out_data); end
      tests_run++; if ({out_last, out_src, sel, busy} !== 4'b0000) begin tests_failed++; $display("FAIL reset_ctrl got=%b exp=0000", {out_last, out_src, sel, busy}); end
      tests_run++; if ({req_ready_0, req_ready_1} !== 2'b00) begin tests_failed++; $display("FAIL reset_ready got=%b exp=00", {req_ready_0, req_ready_1}); end
      tests_run++; if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
   endtask

   task automatic test_single;
      restart();
      q0.push_back(9'h0A1); q0.push_back(9'h0A2); q0.push_back(9'h1A3);
      tick(1);
      tests_run++; if ({sel, busy, req_ready_0, req_ready_1} !== 4'b0110) begin tests_failed++; $display("FAIL single_grant got=%b exp=0110", {sel, busy, req_ready_0, req_ready_1}); end
      tick(1);
      tests_run++; if ({out_valid, out_src, out_last, out_data} !== 11'b1_0_0_10100001) begin tests_failed++; $display("FAIL single_beat1 got=%b_%b_%b_%h exp=1_0_0_a1", out_valid, out_src, out_last, out_data); end
      tick(1);
      tests_run++; if (out_data !== 8'hA2) begin tests_failed++; $display("FAIL single_beat2 got=%h exp=a2", out_data); end
      tick(1);
      tests_run++; if ({out_last, out_data, busy} !== 10'b1_10100011_0) begin tests_failed++; $display("FAIL single_beat3 got=%b_%h_%b exp=1_a3_0", out_last, out_data, busy); end
      tick(2);
      exp_q = '{10'h0A1, 10'h0A2, 10'h1A3};
      tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL single_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL single_seq[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_contention;
      restart();
      q0.push_back(9'h010); q0.push_back(9'h111); q0.push_back(9'h012); q0.push_back(9'h113);
      q1.push_back(9'h020); q1.push_back(9'h121); q1.push_back(9'h022); q1.push_back(9'h123);
      tick(3);
      tests_run++; if ({busy, sel} !== 2'b00) begin tests_failed++; $display("FAIL contention_bubble got=%b exp=00", {busy, sel}); end
      tick(1);
      tests_run++; if ({busy, sel} !== 2'b11) begin tests_failed++; $display("FAIL contention_grant1 got=%b exp=11", {busy, sel}); end
      tick(10);
      exp_q = '{10'h010, 10'h111, 10'h220, 10'h321, 10'h012, 10'h113, 10'h222, 10'h323};
      tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL contention_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL contention_seq[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_truncation;
      restart();
      for (int i = 1; i <= 6; i++) q1.push_back({(i == 6), 8'h30 + 8'(i)});
      tick(5);
      tests_run++; if ({out_data, out_last, busy} !== 10'b00110100_0_0) begin tests_failed++; $display("FAIL trunc_end got=%h_%b_%b exp=34_0_0", out_data, out_last, busy); end
      tick(1);
      tests_run++; if ({busy, sel} !== 2'b11) begin tests_failed++; $display("FAIL trunc_regrant got=%b exp=11", {busy, sel}); end
      tick(4);
      exp_q = '{10'h231, 10'h232, 10'h233, 10'h234, 10'h235, 10'h336};
      tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL trunc_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL trunc_seq[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_backpressure;
      restart();
      q0.push_back(9'h041); q0.push_back(9'h042); q0.push_back(9'h043); q0.push_back(9'h144);
      tick(2);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests_run++; if ({out_valid, req_ready_0, out_data} !== 10'b1_0_01000001) begin tests_failed++; $display("FAIL bp_hold[%0d] got=%b_%b_%h exp=1_0_41", i, out_valid, req_ready_0, out_data); end
         tick(1);
      end
      out_ready = 1'b1;
      tick(7);
      exp_q = '{10'h041, 10'h042, 10'h043, 10'h144};
      tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL bp_seq[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid;
      restart();
      q0.push_back(9'h051); q0.push_back(9'h052); q0.push_back(9'h153);
      tick(2);
      reset = 1'b1;
      tick(1);
      tests_run++; if ({out_valid, out_last, out_src, sel, busy, req_ready_0, req_ready_1} !== 7'b0) begin tests_failed++; $display("FAIL rstmid_ctrl got=%b exp=0000000", {out_valid, out_last, out_src, sel, busy, req_ready_0, req_ready_1}); end
      tests_run++; if ({out_data, state_dbg} !== 10'b0) begin tests_failed++; $display("FAIL rstmid_data got=%h_%0d exp=00_0", out_data, state_dbg); end
      reset = 1'b0;
      q0.delete();
      got_q.delete();
      q1.push_back(9'h061); q1.push_back(9'h162);
      tick(1);
      tests_run++; if ({busy, sel} !== 2'b11) begin tests_failed++; $display("FAIL rstmid_grant got=%b exp=11", {busy, sel}); end
      tick(4);
      exp_q = '{10'h261, 10'h362};
      tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL rstmid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL rstmid_seq[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_valid_gap;
      restart();
      q0.push_back(9'h071); q0.push_back(9'h072); q0.push_back(9'h173);
      q1.push_back(9'h181);
      tick(2);
      gap_0 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick(1);
         tests_run++; if ({busy, sel, req_ready_1} !== 3'b100) begin tests_failed++; $display("FAIL gap_hold[%0d] got=%b exp=100", i, {busy, sel, req_ready_1}); end
      end
      gap_0 = 1'b0;
      tick(8);
      exp_q = '{10'h071, 10'h072, 10'h173, 10'h381};
      tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL gap_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL gap_seq[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single();
      test_contention();
      test_truncation();
      test_backpressure();
      test_reset_mid();
      test_valid_gap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
